// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: output register plus one-entry skid buffer,
// giving 1-cycle latency and full throughput under back-pressure.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a held op stays unchanged.
  localparam int PW = XLEN + 3;

  logic [XLEN-1:0]  sum_c, diff_c, res_c;
  logic             zero_c, ovf_c, ill_c;
  logic [PW-1:0]    new_data_c;
  logic             accept_c, drain_c;

  logic             o_valid_q, o_valid_d;
  logic [PW-1:0]    o_data_q, o_data_d;
  logic             s_valid_q, s_valid_d;
  logic [PW-1:0]    s_data_q, s_data_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign sum_c  = op_a + op_b;
  assign diff_c = op_a - op_b;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (alu_ctrl)
      4'b0000: res_c = op_a & op_b;
      4'b0001: res_c = op_a | op_b;
      4'b0010: begin
        res_c = sum_c;
        ovf_c = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum_c[XLEN-1] != op_a[XLEN-1]);
      end
      4'b0110: begin
        res_c = diff_c;
        ovf_c = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff_c[XLEN-1] != op_a[XLEN-1]);
      end
      default: ill_c = 1'b1;
    endcase
    zero_c     = !ill_c && (res_c == '0);
    new_data_c = {res_c, zero_c, ovf_c, ill_c};
  end

  // in_ready depends only on the skid flop and flush, never on out_ready.
  assign in_ready = !s_valid_q && !flush;
  assign accept_c = in_valid && in_ready;
  assign drain_c  = o_valid_q && out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    err_d     = err_q;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      if (s_valid_q && drain_c) begin
        o_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept_c && (!o_valid_q || drain_c)) begin
        o_data_d  = new_data_c;
        o_valid_d = 1'b1;
      end else if (accept_c) begin
        s_data_d  = new_data_c;
        s_valid_d = 1'b1;
      end else if (drain_c) begin
        o_valid_d = 1'b0;
      end
      if (accept_c && ill_c && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      err_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      err_q     <= err_d;
    end
  end

  assign out_valid                    = o_valid_q;
  assign {result, zero, ovf, illegal} = o_data_q;
  assign err_count                    = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: scoreboard of expected results,
// plus directed back-pressure, flush, illegal-count and async-reset checks.
module tb_alu_exec_stage;

  localparam int XLEN  = 32;
  localparam int ERR_W = 8;
  localparam int PW    = XLEN + 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             zero;
  logic             ovf;
  logic             illegal;
  logic [ERR_W-1:0] err_count;

  alu_exec_stage #(.XLEN(XLEN), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .illegal(illegal),
    .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [PW-1:0]    exp_q[$];
  int               lat_q[$];
  int               n_cmp   = 0;
  int               n_mis   = 0;
  int               n_deliv = 0;
  logic             chk_lat = 1'b0;
  logic [ERR_W-1:0] err_exp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: ADD/SUB overflow judged by exact signed 64-bit arithmetic.
  function automatic logic [PW-1:0] model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    longint sa, sb, wide, lim;
    logic [XLEN-1:0] r;
    logic o;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    lim  = 64'sd2147483648;
    o    = 1'b0;
    r    = '0;
    wide = 0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin wide = sa + sb; r = wide[XLEN-1:0]; o = (wide >= lim) || (wide < -lim); end
      4'b0110: begin wide = sa - sb; r = wide[XLEN-1:0]; o = (wide >= lim) || (wide < -lim); end
      default: return {{XLEN{1'b0}}, 1'b0, 1'b0, 1'b1};
    endcase
    return {r, (r == '0), o, 1'b0};
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [PW-1:0] e;
    int            acc_cyc;
    if (rst_n && !flush && out_valid && out_ready) begin
      n_deliv++;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e       = exp_q.pop_front();
        acc_cyc = lat_q.pop_front();
        check("out", 64'({result, zero, ovf, illegal}), 64'(e));
        if (acc_cyc >= 0) check("latency", 64'(cyc - acc_cyc), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic acc);
    logic [PW-1:0] m;
    in_valid = v;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    acc = v && in_ready && rst_n;
    if (acc) begin
      m = model(c, a, b);
      exp_q.push_back(m);
      lat_q.push_back(chk_lat ? cyc : -1);
      if (m[0] && err_exp != {ERR_W{1'b1}}) err_exp++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) drive_op(1'b0, 4'b0000, '0, '0, acc);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]      ctrl_tab[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1111, 4'b0011};
  logic [3:0]      b_ctrl[7]   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0010};
  logic [XLEN-1:0] b_a[7]      = '{32'd5, 32'd7, 32'h0000F0F0, 32'h0000F000, 32'h7FFFFFFF,
                                   32'h80000000, 32'hFFFFFFFF};
  logic [XLEN-1:0] b_b[7]      = '{32'd7, 32'd7, 32'h00000FF0, 32'h0000000F, 32'd1, 32'd1, 32'd1};

  initial begin
    logic          acc;
    int            d0, tries;
    logic [PW:0]   held;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_payload", 64'({result, zero, ovf, illegal}), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic ops and overflow cases, back-to-back with 1-cycle latency
    chk_lat = 1'b1;
    d0 = n_deliv;
    for (int i = 0; i < 7; i++) begin
      drive_op(1'b1, b_ctrl[i], b_a[i], b_b[i], acc);
      check("basic_acc", 64'(acc), 64'd1);
    end
    idle(2);
    check("basic_count", 64'(n_deliv - d0), 64'd7);

    // random traffic with random back-pressure
    chk_lat = 1'b0;
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive_op(1'($urandom_range(0, 3) != 0), ctrl_tab[$urandom_range(0, 5)],
               $urandom, ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom, acc);
    end
    out_ready = 1'b1;
    idle(4);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_err", 64'(err_count), 64'(err_exp));

    // back-pressure: two accepted, third refused, held output stable
    out_ready = 1'b0;
    d0 = n_deliv;
    drive_op(1'b1, 4'b0010, 32'd100, 32'd23, acc);
    check("bp_acc1", 64'(acc), 64'd1);
    drive_op(1'b1, 4'b0110, 32'd50, 32'd8, acc);
    check("bp_acc2", 64'(acc), 64'd1);
    drive_op(1'b1, 4'b0001, 32'h00A0, 32'h000B, acc);
    check("bp_acc3_refused", 64'(acc), 64'd0);
    held = {out_valid, result, zero, ovf, illegal};
    check("bp_out_valid", 64'(out_valid), 64'd1);
    idle(2);
    check("bp_stable", 64'({out_valid, result, zero, ovf, illegal}), 64'(held));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 6) begin
      drive_op(1'b1, 4'b0001, 32'h00A0, 32'h000B, acc);
      tries++;
    end
    check("bp_retry_cycles", 64'(tries), 64'd2);
    idle(3);
    check("bp_count", 64'(n_deliv - d0), 64'd3);

    // illegal codes and counter
    drive_op(1'b1, 4'b1111, 32'h1234, 32'h5678, acc);
    drive_op(1'b1, 4'b0011, 32'h0, 32'h0, acc);
    idle(2);
    check("ill_err", 64'(err_count), 64'(err_exp));

    // flush with O and S full and an illegal op offered in the same cycle
    out_ready = 1'b0;
    drive_op(1'b1, 4'b0010, 32'd1, 32'd2, acc);
    check("fl_acc1", 64'(acc), 64'd1);
    drive_op(1'b1, 4'b0010, 32'd3, 32'd4, acc);
    check("fl_acc2", 64'(acc), 64'd1);
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_err", 64'(err_count), 64'(err_exp));
    chk_lat = 1'b1;
    d0 = n_deliv;
    drive_op(1'b1, 4'b0110, 32'd9, 32'd10, acc);
    idle(2);
    check("fl_after_count", 64'(n_deliv - d0), 64'd1);
    chk_lat = 1'b0;

    // saturation of the illegal-op counter
    for (int i = 0; i < 300; i++) drive_op(1'b1, 4'($urandom_range(7, 15)), $urandom, $urandom, acc);
    idle(2);
    check("sat_err", 64'(err_count), 64'd255);
    check("sat_model", 64'(err_count), 64'(err_exp));

    // asynchronous reset with O and S full
    out_ready = 1'b0;
    drive_op(1'b1, 4'b0001, 32'hDEAD0000, 32'h0000BEEF, acc);
    drive_op(1'b1, 4'b0010, 32'd11, 32'd22, acc);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_payload", 64'({result, zero, ovf, illegal}), 64'd0);
    check("arst_err", 64'(err_count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    lat_q.delete();
    err_exp = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    d0 = n_deliv;
    drive_op(1'b1, 4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, acc);
    idle(2);
    check("arst_after_count", 64'(n_deliv - d0), 64'd1);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
